func_sched: RTL and testbench
=============================

# func_sched

Operand scheduler and result collector for the a·√b compute block. Buffers operand pairs from the host in a small FIFO and launches one computation at a time over the compute block's start/busy handshake. It holds the operands stable for the whole computation, then captures each 16-bit result with a one-cycle valid strobe. It sits directly upstream of the compute block (drives its start/a/b inputs) and consumes its busy/y outputs.

## Interface
- DEPTH, 4, operand FIFO depth; power of two, 2..16
- TMO, 3, max cycles to wait for calc_busy_i to rise after a launch
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- a_bi  in  8  operand a
- b_bi  in  8  operand b (radicand)
- push_i  in  1  enqueue {a_bi,b_bi} this cycle
- full_o  out  1  FIFO holds DEPTH entries
- busy_o  out  1  FIFO non-empty or FSM not IDLE
- calc_start_o  out  1  start strobe to compute block
- calc_a_o  out  8  operand a to compute block
- calc_b_o  out  8  operand b to compute block
- calc_busy_i  in  1  compute block busy
- calc_y_i  in  16  compute block result
- y_bo  out  16  last captured result
- y_valid_o  out  1  one-cycle pulse when y_bo updates
- res_cnt_o  out  8  results captured, wraps 255→0
- ovf_o  out  1  sticky: push dropped while full
- err_o  out  1  sticky: launch timed out

## Operation
- Reset (async, rst_i=1): FIFO empty, FSM IDLE, all outputs 0. ovf_o and err_o clear only on reset.
- FIFO: push_i with count<DEPTH writes at tail. push_i with count==DEPTH is dropped and sets ovf_o, even if a pop occurs the same cycle. Simultaneous push and pop on a non-full FIFO leaves count unchanged. Pointers wrap modulo DEPTH.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, CAPTURE.
  - IDLE: if count>0, pop head into calc_a_o/calc_b_o, then go to LAUNCH.
  - LAUNCH: calc_start_o=1 for exactly this cycle. Go to WAIT_BUSY.
  - WAIT_BUSY: calc_start_o=0. If calc_busy_i=1, go to WAIT_DONE. Otherwise increment the timeout counter. After TMO cycles without busy, set err_o, discard the operand pair, and go to IDLE (no y_valid_o pulse).
  - WAIT_DONE: remain while calc_busy_i=1. On calc_busy_i=0, go to CAPTURE.
  - CAPTURE: y_bo<=calc_y_i, y_valid_o=1, res_cnt_o+=1, then go to IDLE.
- calc_a_o/calc_b_o are stable from LAUNCH through CAPTURE. They change only on a pop in IDLE.
- calc_start_o, y_valid_o, and busy_o decode from registered state only (glitch-free, no input→output combinational path).
- No arithmetic on data. y_bo is a straight 16-bit capture.

## Timing
- Push in cycle t to an empty FIFO in IDLE: count=1 in t+1; pop at end of t+1; calc_start_o high in t+2.
- Minimum back-to-back spacing: the next LAUNCH comes 2 cycles after CAPTURE (IDLE pop cycle, then LAUNCH).
- Result latency: y_valid_o is high the cycle after the first cycle calc_busy_i is sampled low in WAIT_DONE.
- busy_o goes high the cycle after the first accepted push. It falls the cycle after CAPTURE (or timeout) when the FIFO is empty.
- Reset mid-computation: all state clears immediately. Queued operands are lost. calc_start_o is 0 while rst_i=1.

## Test plan
- Single op: push a=3, b=16 → one calc_start_o pulse with calc_a_o=3, calc_b_o=16; y_bo=12, y_valid_o one cycle, res_cnt_o=1.
- Burst: push (255,255), (10,0), (7,81), (1,1) on consecutive cycles → exactly four launches in order; y_bo sequence 3825, 0, 63, 1; res_cnt_o=4; ovf_o=0.
- Overflow: with compute block stalled busy, push DEPTH+2 pairs → full_o=1 after DEPTH pushes, ovf_o=1, only DEPTH results produced.
- Timeout: compute model never asserts busy → err_o=1 exactly TMO+2 cycles after calc_start_o, no y_valid_o; the next queued op still launches.
- Reset mid-op: assert rst_i during WAIT_DONE with 2 entries queued → all outputs 0 asynchronously; no launch after release until a new push.
- Counter wrap: 256 ops → res_cnt_o returns to 0; y_bo of last op correct.

Source files
------------

// File: rtl/func_sched_if.sv
// Host push port and compute-block handshake of the a*sqrt(b) operand scheduler.
interface func_sched_if;
   logic [7:0]  a_bi;
   logic [7:0]  b_bi;
   logic        push_i;
   logic        full_o;
   logic        busy_o;
   logic        calc_start_o;
   logic [7:0]  calc_a_o;
   logic [7:0]  calc_b_o;
   logic        calc_busy_i;
   logic [15:0] calc_y_i;
   logic [15:0] y_bo;
   logic        y_valid_o;
   logic [7:0]  res_cnt_o;
   logic        ovf_o;
   logic        err_o;

   modport slave (
      input  a_bi, b_bi, push_i, calc_busy_i, calc_y_i,
      output full_o, busy_o, calc_start_o, calc_a_o, calc_b_o,
             y_bo, y_valid_o, res_cnt_o, ovf_o, err_o
   );

   modport master (
      output a_bi, b_bi, push_i, calc_busy_i, calc_y_i,
      input  full_o, busy_o, calc_start_o, calc_a_o, calc_b_o,
             y_bo, y_valid_o, res_cnt_o, ovf_o, err_o
   );
endinterface

// File: rtl/func_sched.sv
// Operand FIFO plus launch/capture FSM in front of the a*sqrt(b) compute block.
// One computation in flight; operands held from launch until the result is captured.
module func_sched #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned TMO   = 3
) (
   input  logic        clk_i,
   input  logic        rst_i,
   func_sched_if.slave bus
);
   localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
   localparam int unsigned TMO_W  = (TMO > 0) ? $clog2(TMO + 1) : 1;
   localparam int unsigned DAT_W  = 8;
   localparam int unsigned RES_W  = 16;
   localparam int unsigned RCNT_W = 8;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LAUNCH    = 3'd1,
      WAIT_BUSY = 3'd2,
      WAIT_DONE = 3'd3,
      CAPTURE   = 3'd4
   } state_t;

   typedef struct packed {
      logic [DAT_W-1:0] a;
      logic [DAT_W-1:0] b;
   } opnd_t;

   opnd_t             mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   state_t            state_q, state_d;
   logic [DAT_W-1:0]  calc_a_q, calc_a_d;
   logic [DAT_W-1:0]  calc_b_q, calc_b_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic [RES_W-1:0]  y_q, y_d;
   logic [RCNT_W-1:0] res_cnt_q, res_cnt_d;
   logic              ovf_q, ovf_d;
   logic              err_q, err_d;
   logic              full_q, full_d;
   logic              busy_q, busy_d;
   logic              start_q, start_d;
   logic              y_valid_q, y_valid_d;
   logic              push_ok;
   logic              pop;

   // Operand storage carries no control meaning, so it is left out of reset.
   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= opnd_t'({bus.a_bi, bus.b_bi});
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         calc_a_q  <= '0;
         calc_b_q  <= '0;
         tmo_q     <= '0;
         y_q       <= '0;
         res_cnt_q <= '0;
         ovf_q     <= 1'b0;
         err_q     <= 1'b0;
         full_q    <= 1'b0;
         busy_q    <= 1'b0;
         start_q   <= 1'b0;
         y_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         calc_a_q  <= calc_a_d;
         calc_b_q  <= calc_b_d;
         tmo_q     <= tmo_d;
         y_q       <= y_d;
         res_cnt_q <= res_cnt_d;
         ovf_q     <= ovf_d;
         err_q     <= err_d;
         full_q    <= full_d;
         busy_q    <= busy_d;
         start_q   <= start_d;
         y_valid_q <= y_valid_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      calc_a_d  = calc_a_q;
      calc_b_d  = calc_b_q;
      tmo_d     = tmo_q;
      y_d       = y_q;
      res_cnt_d = res_cnt_q;
      ovf_d     = ovf_q;
      err_d     = err_q;
      pop       = 1'b0;

      // Fullness is judged on the registered count: a same-cycle pop does not rescue a push.
      push_ok = bus.push_i && (count_q != CNT_W'(DEPTH));
      if (bus.push_i && !push_ok) begin
         ovf_d = 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (count_q != '0) begin
               pop      = 1'b1;
               calc_a_d = mem_q[rd_ptr_q].a;
               calc_b_d = mem_q[rd_ptr_q].b;
               state_d  = LAUNCH;
            end
         end
         LAUNCH: begin
            tmo_d   = '0;
            state_d = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (bus.calc_busy_i) begin
               state_d = WAIT_DONE;
            end else if (tmo_q == TMO_W'(TMO)) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         WAIT_DONE: begin
            // Result is taken on the busy fall so y_bo and y_valid_o appear together.
            if (!bus.calc_busy_i) begin
               y_d       = bus.calc_y_i;
               res_cnt_d = res_cnt_q + RCNT_W'(1);
               state_d   = CAPTURE;
            end
         end
         CAPTURE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({push_ok, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      // Status strobes are registered copies of the next-state decode.
      start_d   = (state_d == LAUNCH);
      y_valid_d = (state_d == CAPTURE);
      busy_d    = (count_d != '0) || (state_d != IDLE);
      full_d    = (count_d == CNT_W'(DEPTH));
   end

   assign bus.full_o       = full_q;
   assign bus.busy_o       = busy_q;
   assign bus.calc_start_o = start_q;
   assign bus.calc_a_o     = calc_a_q;
   assign bus.calc_b_o     = calc_b_q;
   assign bus.y_bo         = y_q;
   assign bus.y_valid_o    = y_valid_q;
   assign bus.res_cnt_o    = res_cnt_q;
   assign bus.ovf_o        = ovf_q;
   assign bus.err_o        = err_q;
endmodule

// File: tb/tb_func_sched.sv
// Bench for func_sched: table vectors, corner-case sequences and a randomized run
// against a queue-based reference and a behavioural a*floor(sqrt(b)) compute block.
`timescale 1ns/1ps
module tb_func_sched;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned TMO   = 3;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
   } pair_t;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      int          dly;
      int          len;
      logic [15:0] y;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   func_sched_if bus();

   func_sched #(.DEPTH(DEPTH), .TMO(TMO)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int push_cyc = 0;
   int drop_cyc = 0;
   int err_cyc  = -1;

   always @(posedge clk) cyc <= cyc + 1;

   // compute block model controls
   int         cm_ph = 0;
   int         cm_cnt, cm_ln;
   logic [7:0] cm_a, cm_b;
   int         cfg_dly = 1;
   int         cfg_len = 2;
   bit         cfg_rand = 1'b0;
   bit         cm_stall = 1'b0;
   int         cm_dead_n = 0;

   pair_t       lq[$];
   logic [15:0] yq[$];
   int          sq[$];
   int          vq[$];
   vec_t        vt[8];

   function automatic int isqrt(input int v);
      int r = 0;
      while ((r + 1) * (r + 1) <= v) r++;
      return r;
   endfunction

   function automatic logic [15:0] ref_y(input logic [7:0] a, input logic [7:0] b);
      return 16'(int'(a) * isqrt(int'(b)));
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive_push(input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      bus.a_bi   = a;
      bus.b_bi   = b;
      bus.push_i = 1'b1;
      push_cyc   = cyc;
   endtask

   task automatic drive_idle();
      @(negedge clk);
      bus.push_i = 1'b0;
   endtask

   task automatic clear_logs();
      lq.delete(); yq.delete(); sq.delete(); vq.delete();
      err_cyc = -1;
   endtask

   task automatic do_reset();
      bus.push_i = 1'b0;
      cm_stall   = 1'b0;
      cm_dead_n  = 0;
      cfg_rand   = 1'b0;
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      clear_logs();
      @(negedge clk);
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      while ((bus.busy_o || cm_ph != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(n < budget), 32'd1);
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_stalled(input string name);
      int n = 0;
      while (cm_ph != 2 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(n < 40), 32'd1);
      repeat (2) @(negedge clk);
   endtask

   // Behavioural compute block: busy after a delay, held for a length, result on the fall.
   initial begin
      bus.calc_busy_i = 1'b0;
      bus.calc_y_i    = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            bus.calc_busy_i = 1'b0;
            bus.calc_y_i    = '0;
            cm_ph           = 0;
         end else begin
            case (cm_ph)
               0: if (bus.calc_start_o) begin
                  if (cm_dead_n > 0) begin
                     cm_dead_n--;
                  end else begin
                     cm_a   = bus.calc_a_o;
                     cm_b   = bus.calc_b_o;
                     cm_cnt = cfg_rand ? int'($urandom_range(TMO + 1, 1)) : cfg_dly;
                     cm_ln  = cfg_rand ? int'($urandom_range(4, 1)) : cfg_len;
                     cm_ph  = 1;
                  end
               end
               1: begin
                  cm_cnt--;
                  if (cm_cnt == 0) begin
                     bus.calc_busy_i = 1'b1;
                     bus.calc_y_i    = 16'($urandom);
                     cm_ph           = 2;
                  end
               end
               2: if (!cm_stall) begin
                  cm_ln--;
                  if (cm_ln == 0) begin
                     bus.calc_busy_i = 1'b0;
                     bus.calc_y_i    = ref_y(cm_a, cm_b);
                     drop_cyc        = cyc;
                     cm_ph           = 0;
                  end
               end
               default: cm_ph = 0;
            endcase
         end
      end
   end

   // Output monitor: launches, results and first error cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (bus.calc_start_o) begin
               lq.push_back(pair_t'({bus.calc_a_o, bus.calc_b_o}));
               sq.push_back(cyc);
            end
            if (bus.y_valid_o) begin
               yq.push_back(bus.y_bo);
               vq.push_back(cyc);
            end
            if (bus.err_o && err_cyc < 0) err_cyc = cyc;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      pair_t       eq[$];
      pair_t       bp[4];
      logic [15:0] by[4];
      logic [7:0]  ra, rb;
      int          n, guard, r0;

      bus.push_i = 1'b0;
      bus.a_bi   = '0;
      bus.b_bi   = '0;

      vt[0] = '{8'd3,   8'd16,  1, 2, 16'd12};
      vt[1] = '{8'd255, 8'd255, 2, 3, 16'd3825};
      vt[2] = '{8'd10,  8'd0,   1, 1, 16'd0};
      vt[3] = '{8'd7,   8'd81,  int'(TMO) + 1, 1, 16'd63};
      vt[4] = '{8'd1,   8'd1,   3, 4, 16'd1};
      vt[5] = '{8'd200, 8'd100, 1, 5, 16'd2000};
      vt[6] = '{8'd0,   8'd200, 2, 1, 16'd0};
      vt[7] = '{8'd17,  8'd99,  4, 2, 16'd153};

      // reset values while reset is held
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_ctrl", 32'({bus.full_o, bus.busy_o, bus.calc_start_o, bus.y_valid_o,
                             bus.ovf_o, bus.err_o}), 32'd0);
      check("rst_data", 32'({bus.calc_a_o, bus.calc_b_o, bus.res_cnt_o}), 32'd0);
      check("rst_y", 32'(bus.y_bo), 32'd0);
      rst = 1'b0;
      clear_logs();
      @(negedge clk);

      // table vectors: one op each, isolated
      for (int i = 0; i < 8; i++) begin
         r0 = int'(bus.res_cnt_o);
         cfg_dly = vt[i].dly;
         cfg_len = vt[i].len;
         clear_logs();
         drive_push(vt[i].a, vt[i].b);
         drive_idle();
         wait_idle("vec_idle", 80);
         check("vec_nlaunch", 32'(lq.size()), 32'd1);
         if (lq.size() > 0) begin
            check("vec_a", 32'(lq[0].a), 32'(vt[i].a));
            check("vec_b", 32'(lq[0].b), 32'(vt[i].b));
            check("vec_start_lat", 32'(sq[0] - push_cyc), 32'd2);
         end
         check("vec_nres", 32'(yq.size()), 32'd1);
         if (yq.size() > 0) begin
            check("vec_y", 32'(yq[0]), 32'(vt[i].y));
            check("vec_valid_lat", 32'(vq[0] - drop_cyc), 32'd1);
         end
         check("vec_res_cnt", 32'(bus.res_cnt_o), 32'(8'(r0 + 1)));
         check("vec_err", 32'(bus.err_o), 32'd0);
      end

      // burst of four on consecutive cycles
      do_reset();
      cfg_dly = 1;
      cfg_len = 2;
      bp[0] = '{8'd255, 8'd255}; bp[1] = '{8'd10, 8'd0};
      bp[2] = '{8'd7, 8'd81};    bp[3] = '{8'd1, 8'd1};
      by[0] = 16'd3825; by[1] = 16'd0; by[2] = 16'd63; by[3] = 16'd1;
      for (int k = 0; k < 4; k++) drive_push(bp[k].a, bp[k].b);
      drive_idle();
      wait_idle("burst_idle", 200);
      check("burst_nlaunch", 32'(lq.size()), 32'd4);
      check("burst_nres", 32'(yq.size()), 32'd4);
      for (int k = 0; k < 4; k++) begin
         if (k < lq.size()) check("burst_pair", 32'(lq[k]), 32'(bp[k]));
         if (k < yq.size()) check("burst_y", 32'(yq[k]), 32'(by[k]));
      end
      if (sq.size() > 1 && vq.size() > 0) check("b2b_gap", 32'(sq[1] - vq[0]), 32'd2);
      check("burst_res_cnt", 32'(bus.res_cnt_o), 32'd4);
      check("burst_ovf", 32'(bus.ovf_o), 32'd0);

      // overflow while the compute block is stalled busy
      do_reset();
      cfg_dly = 1;
      cfg_len = 1;
      cm_stall = 1'b1;
      eq.delete();
      drive_push(8'd9, 8'd4);
      eq.push_back('{8'd9, 8'd4});
      drive_idle();
      wait_stalled("ovf_stall");
      for (int i = 0; i < int'(DEPTH); i++) begin
         drive_push(8'(20 + i), 8'(i * i));
         eq.push_back('{8'(20 + i), 8'(i * i)});
         if (i == int'(DEPTH) - 1) check("ovf_not_full", 32'(bus.full_o), 32'd0);
      end
      drive_idle();
      check("ovf_full", 32'(bus.full_o), 32'd1);
      check("ovf_clear", 32'(bus.ovf_o), 32'd0);
      drive_push(8'd100, 8'd1);
      drive_push(8'd101, 8'd4);
      drive_idle();
      check("ovf_set", 32'(bus.ovf_o), 32'd1);
      check("ovf_still_full", 32'(bus.full_o), 32'd1);
      cm_stall = 1'b0;
      wait_idle("ovf_idle", 300);
      check("ovf_nres", 32'(yq.size()), 32'(DEPTH + 1));
      for (int k = 0; k < yq.size() && k < eq.size(); k++)
         check("ovf_y", 32'(yq[k]), 32'(ref_y(eq[k].a, eq[k].b)));
      check("ovf_res_cnt", 32'(bus.res_cnt_o), 32'(DEPTH + 1));
      check("ovf_sticky", 32'({bus.ovf_o, bus.full_o}), 32'd2);

      // launch timeout: first op never sees busy, second op proceeds
      do_reset();
      cfg_dly = 1;
      cfg_len = 2;
      cm_dead_n = 1;
      drive_push(8'd5, 8'd36);
      drive_push(8'd6, 8'd49);
      drive_idle();
      wait_idle("tmo_idle", 100);
      check("tmo_err", 32'(bus.err_o), 32'd1);
      if (sq.size() > 0) check("tmo_latency", 32'(err_cyc - sq[0]), 32'(TMO + 2));
      check("tmo_nlaunch", 32'(lq.size()), 32'd2);
      if (lq.size() > 1) check("tmo_next_a", 32'(lq[1].a), 32'd6);
      check("tmo_nres", 32'(yq.size()), 32'd1);
      if (yq.size() > 0) check("tmo_y", 32'(yq[0]), 32'd42);
      check("tmo_res_cnt", 32'(bus.res_cnt_o), 32'd1);

      // asynchronous reset during WAIT_DONE with two ops queued
      do_reset();
      cfg_dly = 1;
      cfg_len = 1;
      drive_push(8'd4, 8'd9);
      drive_idle();
      wait_idle("rmid_first", 50);
      check("rmid_pre_y", 32'(bus.y_bo), 32'd12);
      cm_stall = 1'b1;
      drive_push(8'd2, 8'd4);
      drive_push(8'd3, 8'd9);
      drive_push(8'd4, 8'd16);
      drive_idle();
      wait_stalled("rmid_stall");
      #2 rst = 1'b1;
      #1;
      check("rmid_ctrl", 32'({bus.full_o, bus.busy_o, bus.calc_start_o, bus.y_valid_o,
                              bus.ovf_o, bus.err_o}), 32'd0);
      check("rmid_data", 32'({bus.calc_a_o, bus.calc_b_o, bus.res_cnt_o}), 32'd0);
      check("rmid_y", 32'(bus.y_bo), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      cm_stall = 1'b0;
      clear_logs();
      repeat (20) @(negedge clk);
      check("rmid_no_launch", 32'(lq.size()), 32'd0);
      check("rmid_not_busy", 32'(bus.busy_o), 32'd0);
      drive_push(8'd8, 8'd64);
      drive_idle();
      wait_idle("rmid_after", 50);
      check("rmid_nres", 32'(yq.size()), 32'd1);
      if (yq.size() > 0) check("rmid_new_y", 32'(yq[0]), 32'd64);

      // randomized 256 ops against queue reference; result counter wraps to 0
      do_reset();
      cfg_rand = 1'b1;
      eq.delete();
      n = 0;
      guard = 0;
      while (n < 256 && guard < 20000) begin
         @(negedge clk);
         guard++;
         if ($urandom_range(3, 0) != 0 && !bus.full_o) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            bus.a_bi   = ra;
            bus.b_bi   = rb;
            bus.push_i = 1'b1;
            eq.push_back('{ra, rb});
            n++;
         end else begin
            bus.push_i = 1'b0;
         end
      end
      drive_idle();
      wait_idle("rnd_idle", 6000);
      check("rnd_nlaunch", 32'(lq.size()), 32'd256);
      check("rnd_nres", 32'(yq.size()), 32'd256);
      for (int k = 0; k < lq.size() && k < eq.size(); k++)
         check("rnd_pair", 32'(lq[k]), 32'(eq[k]));
      for (int k = 0; k < yq.size() && k < eq.size(); k++)
         check("rnd_y", 32'(yq[k]), 32'(ref_y(eq[k].a, eq[k].b)));
      check("wrap_res_cnt", 32'(bus.res_cnt_o), 32'd0);
      if (eq.size() > 0)
         check("wrap_last_y", 32'(bus.y_bo), 32'(ref_y(eq[eq.size()-1].a, eq[eq.size()-1].b)));
      check("rnd_flags", 32'({bus.ovf_o, bus.err_o}), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
